// File: rtl/window_buffer.sv
// window_buffer: 3x3 sliding-window generator for a raster-order 8-bit
// grayscale stream. Two line buffers hold the previous two rows. A 3x3
// register window shifts left by one column on every accepted pixel.
// When the window is complete (row >= 2 and col >= 2), the block raises
// o_gradient_start for one cycle. It then stalls input until the
// downstream edge detector signals a result with a rising edge on
// i_gradient_data_ready.
//
// Ports
//   clk                     rising-edge clock
//   n_rst                   asynchronous active-low reset
//   i_sof                   start of frame, qualified by i_pixel_valid
//   i_pixel_valid           i_pixel_data valid this cycle
//   i_pixel_data[7:0]       pixel, row-major, left to right
//   o_pixel_ready           pixel accepted this cycle when valid
//   P0..P8[7:0]             window: P0..P2 top, P3..P5 middle, P6..P8 bottom
//   o_gradient_start        one-cycle pulse, P0..P8 hold a new window
//   i_gradient_data_ready   edge detector result ready
//   o_frame_done            one-cycle pulse after the last pixel of a frame
//
// state  | meaning
// ACCEPT | ready for a pixel; o_pixel_ready=1
// START  | one cycle, o_gradient_start=1, window just completed
// WAIT   | window held; leave on rising edge of i_gradient_data_ready
module window_buffer #(
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       i_sof,
    input  logic       i_pixel_valid,
    input  logic [7:0] i_pixel_data,
    output logic       o_pixel_ready,
    output logic [7:0] P0,
    output logic [7:0] P1,
    output logic [7:0] P2,
    output logic [7:0] P3,
    output logic [7:0] P4,
    output logic [7:0] P5,
    output logic [7:0] P6,
    output logic [7:0] P7,
    output logic [7:0] P8,
    output logic       o_gradient_start,
    input  logic       i_gradient_data_ready,
    output logic       o_frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    typedef logic [CW-1:0] col_t;
    typedef logic [RW-1:0] row_t;

    localparam col_t COL_LAST = col_t'(IMG_WIDTH - 1);
    localparam row_t ROW_LAST = row_t'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        START  = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    col_t       col_q, col_d;
    row_t       row_q, row_d;
    logic [7:0] win_q [0:8];
    logic [7:0] lb1_q [0:IMG_WIDTH-1];
    logic [7:0] lb2_q [0:IMG_WIDTH-1];
    logic       ready_q;
    logic       done_q;

    logic       accept;
    col_t       cur_col;
    row_t       cur_row;
    logic       win_valid;
    logic       last_pix;
    logic [7:0] lb1_rd, lb2_rd;

    assign accept    = i_pixel_valid && (state_q == ACCEPT);
    // A start-of-frame pixel is always (0,0), whatever the counters say.
    assign cur_col   = i_sof ? '0 : col_q;
    assign cur_row   = i_sof ? '0 : row_q;
    assign win_valid = (cur_row >= row_t'(2)) && (cur_col >= col_t'(2));
    assign last_pix  = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    assign lb1_rd    = lb1_q[cur_col];
    assign lb2_rd    = lb2_q[cur_col];

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCEPT: if (accept && win_valid) state_d = START;
            START:  state_d = WAIT;
            WAIT:   if (i_gradient_data_ready && !ready_q) state_d = ACCEPT;
            default: state_d = ACCEPT;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ACCEPT;
            col_q   <= '0;
            row_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            ready_q <= i_gradient_data_ready;
            done_q  <= accept && last_pix;
            if (accept) begin
                win_q[0] <= win_q[1];
                win_q[1] <= win_q[2];
                win_q[2] <= lb2_rd;
                win_q[3] <= win_q[4];
                win_q[4] <= win_q[5];
                win_q[5] <= lb1_rd;
                win_q[6] <= win_q[7];
                win_q[7] <= win_q[8];
                win_q[8] <= i_pixel_data;
            end
        end
    end

    // Line buffers carry no reset: unwritten entries never reach a valid window.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2_q[cur_col] <= lb1_rd;
            lb1_q[cur_col] <= i_pixel_data;
        end
    end

    assign o_pixel_ready    = (state_q == ACCEPT);
    assign o_gradient_start = (state_q == START);
    assign o_frame_done     = done_q;

    assign P0 = win_q[0];
    assign P1 = win_q[1];
    assign P2 = win_q[2];
    assign P3 = win_q[3];
    assign P4 = win_q[4];
    assign P5 = win_q[5];
    assign P6 = win_q[6];
    assign P7 = win_q[7];
    assign P8 = win_q[8];

endmodule

// File: tb/tb_window_buffer.sv
// Self-checking bench for window_buffer with a 4x4 image. The reference
// model keeps a 2-D copy of the current frame. For each completed window,
// it reads the expected 3x3 block directly from that copy.
module tb_window_buffer;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       i_sof = 1'b0;
    logic       i_pixel_valid = 1'b0;
    logic [7:0] i_pixel_data = '0;
    logic       i_gradient_data_ready = 1'b0;
    logic       o_pixel_ready;
    logic       o_gradient_start;
    logic       o_frame_done;
    logic [7:0] p [0:8];

    always #5 clk = ~clk;

    window_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk                   (clk),
        .n_rst                 (n_rst),
        .i_sof                 (i_sof),
        .i_pixel_valid         (i_pixel_valid),
        .i_pixel_data          (i_pixel_data),
        .o_pixel_ready         (o_pixel_ready),
        .P0                    (p[0]),
        .P1                    (p[1]),
        .P2                    (p[2]),
        .P3                    (p[3]),
        .P4                    (p[4]),
        .P5                    (p[5]),
        .P6                    (p[6]),
        .P7                    (p[7]),
        .P8                    (p[8]),
        .o_gradient_start      (o_gradient_start),
        .i_gradient_data_ready (i_gradient_data_ready),
        .o_frame_done          (o_frame_done)
    );

    int         n_chk = 0;
    int         n_err = 0;
    int         mr = 0;
    int         mc = 0;
    logic [7:0] img [0:H-1][0:W-1];
    logic [7:0] exp_win [0:8];
    int         starts = 0;
    int         dones = 0;
    int         done_with_start = 0;
    logic [7:0] p4_log [$];
    logic [7:0] last_p0 = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_window(input string tag);
        for (int k = 0; k < 9; k++)
            check($sformatf("%s_P%0d", tag, k), 32'(p[k]), 32'(exp_win[k]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check("idle_start", 32'(o_gradient_start), 0);
        end
    endtask

    // gap < 0 leaves the DUT in WAIT after a valid window
    task automatic push(input bit sof, input logic [7:0] d, input int gap);
        int r, c;
        bit valid, last;
        if (sof) begin
            mr = 0;
            mc = 0;
        end
        r = mr;
        c = mc;
        img[r][c] = d;
        valid = (r >= 2) && (c >= 2);
        last  = (r == H-1) && (c == W-1);
        if (c == W-1) begin
            mc = 0;
            mr = (r == H-1) ? 0 : r + 1;
        end else begin
            mc = c + 1;
        end

        check("ready_before_accept", 32'(o_pixel_ready), 1);
        i_sof = sof;
        i_pixel_valid = 1'b1;
        i_pixel_data = d;
        step();
        i_sof = 1'b0;
        i_pixel_valid = 1'b0;
        i_pixel_data = 8'($urandom);
        check("gradient_start", 32'(o_gradient_start), 32'(valid));
        check("frame_done", 32'(o_frame_done), 32'(last));
        if (o_frame_done) begin
            dones++;
            if (o_gradient_start) done_with_start++;
        end
        if (valid) begin
            starts++;
            for (int k = 0; k < 9; k++) exp_win[k] = img[r-2+k/3][c-2+k%3];
            check_window("window");
            p4_log.push_back(p[4]);
            last_p0 = p[0];
            check("ready_in_start", 32'(o_pixel_ready), 0);
            step();
            check("start_pulse_width", 32'(o_gradient_start), 0);
            check("done_pulse_width", 32'(o_frame_done), 0);
            if (gap >= 0) begin
                for (int i = 0; i < gap; i++) begin
                    check("ready_in_wait", 32'(o_pixel_ready), 0);
                    check("start_in_wait", 32'(o_gradient_start), 0);
                    check_window("hold");
                    step();
                end
                i_gradient_data_ready = 1'b1;
                check("ready_before_ack", 32'(o_pixel_ready), 0);
                step();
                i_gradient_data_ready = 1'b0;
                check("ready_after_ack", 32'(o_pixel_ready), 1);
                check_window("after_ack");
            end
        end
    endtask

    initial begin
        // S1 reset
        for (int k = 0; k < 9; k++) exp_win[k] = '0;
        n_rst = 1'b0;
        step();
        step();
        n_rst = 1'b1;
        step();
        check("rst_ready", 32'(o_pixel_ready), 1);
        check("rst_start", 32'(o_gradient_start), 0);
        check("rst_done", 32'(o_frame_done), 0);
        check_window("rst");

        // S2..S4: full frame, 16*row+col, long backpressure on the first window
        starts = 0; dones = 0; done_with_start = 0;
        p4_log.delete();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                push(r == 0 && c == 0, 8'(16*r + c),
                     (r == 2 && c == 2) ? 20 : int'($urandom_range(0, 3)));
        check("frame_starts", 32'(starts), 4);
        check("frame_dones", 32'(dones), 1);
        check("done_with_start", 32'(done_with_start), 1);
        check("p4_count", 32'(p4_log.size()), 4);
        if (p4_log.size() == 4) begin
            check("p4_w0", 32'(p4_log[0]), 32'h11);
            check("p4_w1", 32'(p4_log[1]), 32'h12);
            check("p4_w2", 32'(p4_log[2]), 32'h21);
            check("p4_w3", 32'(p4_log[3]), 32'h22);
        end

        // S5: mid-frame sof at (2,1)
        starts = 0;
        for (int i = 0; i < 9; i++) push(i == 0, 8'(16*(i/4) + i%4), 0);
        push(1'b1, 8'hAA, 0);
        for (int i = 0; i < 10; i++) push(1'b0, 8'(8'h40 + i), 1);
        check("sof_starts", 32'(starts), 1);
        check("sof_window_p0", 32'(last_p0), 32'hAA);

        // S6: reset while waiting on the edge detector
        push(1'b0, 8'h5C, -1);
        idle(3);
        check("wait_ready", 32'(o_pixel_ready), 0);
        n_rst = 1'b0;
        #2;
        for (int k = 0; k < 9; k++) exp_win[k] = '0;
        check_window("rst_wait");
        check("rst_wait_ready", 32'(o_pixel_ready), 1);
        step();
        n_rst = 1'b1;
        mr = 0;
        mc = 0;
        step();
        check("post_rst_ready", 32'(o_pixel_ready), 1);
        starts = 0;
        for (int i = 0; i < 11; i++) push(1'b0, 8'($urandom), 0);
        check("post_rst_starts", 32'(starts), 1);

        // randomized streaming with idle gaps and occasional sof
        for (int i = 0; i < 300; i++) begin
            idle($urandom_range(0, 2));
            push($urandom_range(0, 19) == 0, 8'($urandom), $urandom_range(0, 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
